// File: rtl/cdc_hs_tx_if.sv
// cdc_hs_tx_if: handshake bundle for the source side of a 4-phase req/ack crossing.
//   in_valid/in_data/in_ready : local-domain valid/ready word transfer
//   req/tx_data               : request and held word toward the remote domain
//   ack                       : asynchronous acknowledge from the remote domain
//   busy/done                 : transfer-in-progress flag and completion pulse
//   err                       : wait-timeout pulse (only with CDC_HS_TX_TIMEOUT_EN)
// master = the cdc_hs_tx block, slave = local source plus remote endpoint.
interface cdc_hs_tx_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         req;
  logic [N-1:0] tx_data;
  logic         ack;
  logic         busy;
  logic         done;
`ifdef CDC_HS_TX_TIMEOUT_EN
  logic         err;
`endif

  modport master (
    input  in_valid, in_data, ack,
    output in_ready, req, tx_data, busy, done
`ifdef CDC_HS_TX_TIMEOUT_EN
    , output err
`endif
  );

  modport slave (
    output in_valid, in_data, ack,
    input  in_ready, req, tx_data, busy, done
`ifdef CDC_HS_TX_TIMEOUT_EN
    , input err
`endif
  );
endinterface

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source-side endpoint of a 4-phase req/ack clock-domain crossing.
// A word accepted over valid/ready is held on tx_data while req is high; ack is
// synchronized locally and req is lowered only after ack is seen high, with the
// block returning to idle only after ack is seen low again.
// Ports:
//   clk      : clock, all logic on posedge
//   reset_n  : asynchronous active-low reset
//   bus      : cdc_hs_tx_if.master (in_valid, in_data, in_ready, req, tx_data,
//              ack, busy, done, and err when the timeout option is built)
// Parameters: N (word width), SYNC_STAGES (ack synchronizer depth, 2..4),
//             TIMEOUT (max cycles waiting on an ack edge, 1..65535).
// Build option: define CDC_HS_TX_TIMEOUT_EN to add the wait counter and err.
//
// state   | meaning
// IDLE    | no transfer; accepts a word when ack_s is low
// REQ     | req high, tx_data held, waiting for ack_s high
// RELEASE | req low, tx_data held, waiting for ack_s low
module cdc_hs_tx #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  cdc_hs_tx_if.master  bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("cdc_hs_tx: SYNC_STAGES must be 2..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("cdc_hs_tx: TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   in_ready;
  logic                   req_q, req_nxt;
  logic [N-1:0]           tx_data_q, tx_data_nxt;
  logic                   done_q, done_nxt;

`ifdef CDC_HS_TX_TIMEOUT_EN
  logic [15:0]            wait_cnt, wait_cnt_nxt;
  logic                   err_q, err_nxt;
  logic                   timeout_hit;

  assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack};
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  // A late ack from the previous transfer (or a remote leaving reset with ack
  // high) must drain before a new word may be taken.
  assign in_ready = (state == IDLE) && !ack_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
`ifdef CDC_HS_TX_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      req_q     <= req_nxt;
      tx_data_q <= tx_data_nxt;
      done_q    <= done_nxt;
`ifdef CDC_HS_TX_TIMEOUT_EN
      wait_cnt  <= wait_cnt_nxt;
      err_q     <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    req_nxt     = req_q;
    tx_data_nxt = tx_data_q;
    done_nxt    = 1'b0;
`ifdef CDC_HS_TX_TIMEOUT_EN
    err_nxt     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          tx_data_nxt = bus.in_data;
          req_nxt     = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = RELEASE;
        end
`ifdef CDC_HS_TX_TIMEOUT_EN
        else if (timeout_hit) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (!ack_s) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
`ifdef CDC_HS_TX_TIMEOUT_EN
        else if (timeout_hit) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
`ifdef CDC_HS_TX_TIMEOUT_EN
    // Restart the wait on every state change; count only while waiting on ack.
    if (state_nxt != state || state == IDLE) begin
      wait_cnt_nxt = '0;
    end else begin
      wait_cnt_nxt = wait_cnt + 16'd1;
    end
`endif
  end

  assign bus.in_ready = in_ready;
  assign bus.req      = req_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
`ifdef CDC_HS_TX_TIMEOUT_EN
  assign bus.err      = err_q;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: self-checking bench for cdc_hs_tx (directed table, hand-written
// corner sequences, and a randomized run against a timeline reference model).
module tb_cdc_hs_tx;
  localparam int N    = 8;
  localparam int SYNC = 2;
`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int TMO  = 16;
`else
  localparam int TMO  = 1023;
`endif
  localparam int NRND = 800;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  cdc_hs_tx_if #(.N(N)) bus ();

  cdc_hs_tx #(.N(N), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [N-1:0] data;
    int           d1;        // cycles from req seen high to ack raised
    int           d2;        // cycles from req seen low to ack dropped
    int           req_len;   // cycles req is high
    int           done_off;  // cycle of done pulse, acceptance sample = 0
  } vec_t;

  vec_t vecs [4];

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic ack_v);
    reset_n      = 1'b0;
    bus.ack      = ack_v;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  // Reference model state for the randomized run.
  bit           ackh [0:NRND+8];
  function automatic bit ack_s_at(input int c);
    return (c - SYNC >= 0) ? ackh[c-SYNC] : 1'b0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 3, 3, 6, 13};
    vecs[1] = '{8'h3C, 0, 0, 3, 7};
    vecs[2] = '{8'hFF, 1, 5, 4, 13};
    vecs[3] = '{8'h5A, 6, 1, 9, 14};

    // Reset state
    do_reset(1'b0);
    chk_b("rst_in_ready", bus.in_ready, 1'b1);
    chk_b("rst_req", bus.req, 1'b0);
    chk_d("rst_tx_data", bus.tx_data, 8'h00);
    chk_b("rst_busy", bus.busy, 1'b0);
    chk_b("rst_done", bus.done, 1'b0);

    // Table-driven single transfers with a modelled remote responder
    for (int i = 0; i < 4; i++) begin
      int t, rise, last_req, done_t, raise_at, fall, drop_at;
      repeat (SYNC + 1) step();
      chk_b("vec_ready", bus.in_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[i].data;
      rise = -1; last_req = -1; done_t = -1; raise_at = -1; fall = -1; drop_at = -1;
      step();
      t = 1;
      bus.in_valid = 1'b0;
      bus.in_data  = ~vecs[i].data;
      while (done_t < 0 && t < 100) begin
        if (bus.req && rise < 0) rise = t;
        if (bus.req) last_req = t;
        if (bus.busy) chk_d("vec_hold", bus.tx_data, vecs[i].data);
        if (bus.done) done_t = t;
        if (rise >= 0 && raise_at < 0) raise_at = rise + vecs[i].d1;
        if (t == raise_at) bus.ack = 1'b1;
        if (bus.ack && !bus.req && rise >= 0 && fall < 0) begin
          fall    = t;
          drop_at = t + vecs[i].d2;
        end
        if (t == drop_at) bus.ack = 1'b0;
        if (done_t < 0) begin
          step();
          t++;
        end
      end
      chk_i("vec_req_rise", rise, 1);
      chk_i("vec_req_len", last_req - rise + 1, vecs[i].req_len);
      chk_i("vec_done_off", done_t, vecs[i].done_off);
      step();
      chk_b("vec_done_pulse", bus.done, 1'b0);
      chk_b("vec_busy_after", bus.busy, 1'b0);
      chk_d("vec_tx_after", bus.tx_data, vecs[i].data);
    end

    // Back-to-back words with in_valid held high, immediate remote ack
    begin
      logic [N-1:0] words [3];
      int nacc, ndone;
      bit acc;
      words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
      do_reset(1'b0);
      nacc = 0; ndone = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = words[0];
      for (int k = 0; k < 200 && ndone < 3; k++) begin
        if (bus.done) ndone++;
        if (bus.busy && nacc > 0) chk_d("b2b_hold", bus.tx_data, words[nacc-1]);
        bus.ack = bus.req;
        acc = bus.in_valid && bus.in_ready;
        step();
        if (acc) begin
          nacc++;
          if (nacc < 3) bus.in_data = words[nacc];
          else bus.in_valid = 1'b0;
        end
      end
      chk_i("b2b_accepts", nacc, 3);
      chk_i("b2b_dones", ndone, 3);
      chk_d("b2b_last_word", bus.tx_data, 8'h03);
    end

    // ack high out of reset blocks acceptance until it drains
    begin
      do_reset(1'b1);
      repeat (SYNC) step();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC3;
      chk_b("ackhi_ready0", bus.in_ready, 1'b0);
      for (int k = 0; k < 10; k++) begin
        step();
        chk_b("ackhi_ready", bus.in_ready, 1'b0);
        chk_b("ackhi_req", bus.req, 1'b0);
      end
      bus.ack = 1'b0;
      step();
      chk_b("ackhi_ready_s1", bus.in_ready, 1'b0);
      step();
      chk_b("ackhi_ready_s2", bus.in_ready, 1'b1);
      chk_b("ackhi_req_s2", bus.req, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk_b("ackhi_req_s3", bus.req, 1'b1);
      chk_d("ackhi_tx_s3", bus.tx_data, 8'hC3);
    end

    // Asynchronous reset in the middle of REQ
    begin
      do_reset(1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      step();
      bus.in_valid = 1'b0;
      chk_b("mid_req_before", bus.req, 1'b1);
      #3;
      reset_n = 1'b0;
      #1;
      chk_b("mid_req_async", bus.req, 1'b0);
      chk_d("mid_tx_async", bus.tx_data, 8'h00);
      chk_b("mid_busy_async", bus.busy, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc = 0;
      for (int k = 0; k < 6; k++) begin
        chk_b("mid_no_done", bus.done, 1'b0);
        step();
      end
    end

`ifdef CDC_HS_TX_TIMEOUT_EN
    // Timeout with ack tied low
    begin
      do_reset(1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h09;
      step();
      bus.in_valid = 1'b0;
      for (int k = 1; k <= TMO; k++) begin
        chk_b("tmo_req_wait", bus.req, 1'b1);
        chk_b("tmo_err_wait", bus.err, 1'b0);
        chk_b("tmo_done_wait", bus.done, 1'b0);
        step();
      end
      chk_b("tmo_req_drop", bus.req, 1'b0);
      chk_b("tmo_err_pulse", bus.err, 1'b1);
      chk_b("tmo_ready", bus.in_ready, 1'b1);
      chk_b("tmo_busy", bus.busy, 1'b0);
      chk_b("tmo_done", bus.done, 1'b0);
      step();
      chk_b("tmo_err_clear", bus.err, 1'b0);
      chk_b("tmo_done_after", bus.done, 1'b0);
    end
`endif

    // Randomized traffic against a timeline model: each transfer is described
    // by its acceptance sample e, ack rise sample a and ack fall sample b.
    begin
      bit have_tx;
      int e, a, b, done_at, acc_c, rs, cnt;
      logic [N-1:0] cur_w, prev_w, d;
      bit exp_req, exp_busy, exp_done, exp_rdy, v;
      logic [N-1:0] exp_txd;
      do_reset(1'b0);
      have_tx = 0; e = 0; a = -1; b = -1; done_at = -1; acc_c = -1;
      rs = 0; cnt = 0; cur_w = '0; prev_w = '0;
      for (int c = 0; c < NRND; c++) begin
        if (have_tx && b >= 0 && c > b + SYNC) have_tx = 0;
        exp_req  = have_tx && c >= e + 1 && (a < 0 || c <= a + SYNC);
        exp_busy = have_tx && c >= e + 1 && (b < 0 || c <= b + SYNC);
        exp_done = (c == done_at);
        exp_rdy  = !exp_busy && !ack_s_at(c);
        exp_txd  = (acc_c >= 0 && c >= acc_c + 1) ? cur_w : prev_w;
        chk_b("rnd_req", bus.req, exp_req);
        chk_b("rnd_busy", bus.busy, exp_busy);
        chk_b("rnd_done", bus.done, exp_done);
        chk_b("rnd_ready", bus.in_ready, exp_rdy);
        chk_d("rnd_tx_data", bus.tx_data, exp_txd);
`ifdef CDC_HS_TX_TIMEOUT_EN
        chk_b("rnd_err", bus.err, 1'b0);
`endif
        if (rs == 0 && exp_req && !bus.ack) begin
          cnt = $urandom_range(0, 4);
          rs  = 1;
        end
        if (rs == 1) begin
          if (cnt == 0) begin
            bus.ack = 1'b1;
            a  = c;
            rs = 2;
          end else cnt--;
        end
        if (rs == 2 && !exp_req) begin
          cnt = $urandom_range(0, 4);
          rs  = 3;
        end
        if (rs == 3) begin
          if (cnt == 0) begin
            bus.ack = 1'b0;
            b       = c;
            done_at = b + SYNC + 1;
            rs      = 0;
          end else cnt--;
        end
        ackh[c] = bus.ack;
        v = ($urandom_range(0, 2) != 0);
        d = N'($urandom);
        bus.in_valid = v;
        bus.in_data  = d;
        if (v && exp_rdy) begin
          prev_w  = exp_txd;
          cur_w   = d;
          acc_c   = c;
          have_tx = 1;
          e       = c;
          a       = -1;
          b       = -1;
        end
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
